hps_cmd_decoder: RTL and testbench
==================================

HPS_CMD_DECODER -- requirements
Module: hps_cmd_decoder

Interface
REQ-001 Parameter STATUS_WORDS, default 8, sets the number of 16-bit words in the status register (range 1..8).
REQ-002 Port clk_sys  input  1  is the single clock; all state is updated on its rising edge.
REQ-003 Port reset  input  1  is the asynchronous, active-high reset.
REQ-004 Port io_enable  input  1  is the synchronized HPS IO-enable level; high frames one command transaction.
REQ-005 Port io_strobe  input  1  is a one-cycle pulse; it means io_din holds a newly received SPI word.
REQ-006 Port io_din  input  16  is the received SPI word.
REQ-007 Port io_dout  output  16  is the word returned to the SPI slave for the next transfer.
REQ-008 Port cmd  output  16  is the latched command word of the current transaction.
REQ-009 Port cmd_active  output  1  is high while a command is latched and io_enable is high.
REQ-010 Port status  output  16*STATUS_WORDS  is the committed status register.
REQ-011 Port status_set  output  1  is a one-cycle pulse when status is updated.
REQ-012 Port joystick_0  output  32  is the joystick 0 state.
REQ-013 Port buttons  output  16  is the button/switch state.

Function
REQ-014 SHALL implement states IDLE, CMD and DATA.
- IDLE -> CMD when io_enable is high.
- CMD -> DATA on io_strobe; io_din is latched into cmd and word counter wcnt is set to 0.
- DATA: each io_strobe is handled as payload word wcnt, then wcnt increments.
REQ-015 SHALL go to IDLE on any cycle with io_enable low, from any state; this takes priority over a coincident io_strobe, and the strobe is ignored.
REQ-016 wcnt SHALL be 4 bits and saturate at 15; payload words beyond a command's length SHALL be ignored.
REQ-017 cmd 0x001E (STATUS_SET): words 0..STATUS_WORDS-1 SHALL go into a shadow register, LSW first.
- The last word SHALL copy the shadow into status in the same cycle it is captured.
- status_set SHALL pulse one cycle later.
REQ-018 An aborted STATUS_SET, where io_enable falls before the last word, SHALL leave status unchanged and SHALL NOT pulse status_set.
REQ-019 cmd 0x0002 (JOY0): word 0 SHALL write joystick_0[15:0] and word 1 SHALL write joystick_0[31:16]; each half updates immediately and an abort is not rolled back.
REQ-020 cmd 0x0004 (BUTTONS): word 0 SHALL write buttons.
REQ-021 Any other cmd SHALL be accepted and its payload discarded, with no output change.
REQ-022 io_dout SHALL be registered, update only the cycle after an io_strobe or a transition to IDLE, and be 0x0000 unless stated otherwise in REQ-027.
REQ-023 cmd_active SHALL be high in DATA only; cmd SHALL hold its value in IDLE until the next command is latched.

Reset
REQ-024 Asserting reset SHALL immediately force the following, independent of clk_sys:
- state IDLE, wcnt 0;
- cmd, io_dout, joystick_0, buttons, shadow all 0;
- status 0, status_set 0, cmd_active 0.
REQ-025 Reset asserted mid-transaction SHALL discard the transaction; after release, the block SHALL wait in IDLE and SHALL NOT act on any word until io_enable is seen high and a new command word arrives.

Configuration
REQ-026 Macro HPS_CMD_STATUS_GET_EN SHALL compile in command 0x0029 (STATUS_GET).
REQ-027 With HPS_CMD_STATUS_GET_EN defined, STATUS_GET SHALL drive io_dout as follows:
- the cycle after the command strobe: status word 0;
- after payload strobe k: status word k+1;
- after the final status word: 0x0000.
REQ-028 Without HPS_CMD_STATUS_GET_EN, 0x0029 SHALL be treated as an unknown command and io_dout SHALL stay 0x0000.

Verification
REQ-029 Bench SHALL cover at least these scenarios (STATUS_WORDS=8):
- io_enable high, strobes 0x001E then 0x1111..0x8888 -> status = 0x8888_7777_..._1111, status_set pulses once, one cycle after the 8th strobe.
- STATUS_SET with 3 payload words, then io_enable low -> status unchanged, no status_set, state IDLE.
- Words 0x0002, 0xBEEF, 0xDEAD -> joystick_0 = 0xDEADBEEF; then words 0x0004, 0x00A5 -> buttons = 0x00A5.
- With the macro defined, after status is loaded: 0x0029 then 8 dummy strobes -> io_dout sequence 0x1111..0x8888 then 0x0000; without the macro -> io_dout 0x0000 throughout.
- io_strobe in the same cycle io_enable falls -> word ignored; unknown cmd 0x00FF with 20 words -> no output change, wcnt held at 15.
- Reset asserted between clock edges during JOY0 -> all outputs 0 immediately; a payload word sent after release without a new command -> no output change.

Source files
------------

// File: rtl/hps_cmd_decoder.sv
// HPS SPI command decoder: frames commands with io_enable and routes payload words to status, joystick and buttons.
// Optional build macro HPS_CMD_STATUS_GET_EN adds command 0x0029, which streams the status words back on io_dout.
//
//   state | meaning
//   IDLE  | no transaction; waiting for io_enable high
//   CMD   | transaction open; next strobe is the command word
//   DATA  | command latched; strobes are payload words indexed by wcnt
module hps_cmd_decoder #(
    parameter int STATUS_WORDS = 8
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        io_enable,
    input  logic                        io_strobe,
    input  logic [15:0]                 io_din,
    output logic [15:0]                 io_dout,
    output logic [15:0]                 cmd,
    output logic                        cmd_active,
    output logic [16*STATUS_WORDS-1:0]  status,
    output logic                        status_set,
    output logic [31:0]                 joystick_0,
    output logic [15:0]                 buttons
);

    localparam logic [15:0] CMD_STATUS_SET = 16'h001E;
    localparam logic [15:0] CMD_JOY0       = 16'h0002;
    localparam logic [15:0] CMD_BUTTONS    = 16'h0004;
`ifdef HPS_CMD_STATUS_GET_EN
    localparam logic [15:0] CMD_STATUS_GET = 16'h0029;
`endif
    localparam logic [3:0]  LAST_WORD      = 4'(STATUS_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t      state;
    logic [3:0]  wcnt;
    logic [15:0] shadow [STATUS_WORDS];
    logic        status_pend;

`ifdef HPS_CMD_STATUS_GET_EN
    // Indices past the last status word read back as zero.
    function automatic logic [15:0] status_word(input logic [4:0] idx);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < STATUS_WORDS; i++) begin
            if (idx == 5'(i)) begin
                w = status[16*i +: 16];
            end
        end
        return w;
    endfunction
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            cmd         <= '0;
            cmd_active  <= 1'b0;
            io_dout     <= '0;
            status      <= '0;
            status_set  <= 1'b0;
            status_pend <= 1'b0;
            joystick_0  <= '0;
            buttons     <= '0;
            for (int i = 0; i < STATUS_WORDS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            status_set  <= status_pend;
            status_pend <= 1'b0;

            // Dropping io_enable wins over any strobe arriving in the same cycle.
            if (!io_enable) begin
                state      <= IDLE;
                cmd_active <= 1'b0;
                io_dout    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                    end

                    CMD: begin
                        if (io_strobe) begin
                            cmd        <= io_din;
                            wcnt       <= '0;
                            state      <= DATA;
                            cmd_active <= 1'b1;
                            io_dout    <= '0;
`ifdef HPS_CMD_STATUS_GET_EN
                            if (io_din == CMD_STATUS_GET) begin
                                io_dout <= status_word(5'd0);
                            end
`endif
                        end
                    end

                    DATA: begin
                        if (io_strobe) begin
                            if (wcnt != 4'hF) begin
                                wcnt <= wcnt + 4'd1;
                            end
                            io_dout <= '0;
                            case (cmd)
                                CMD_STATUS_SET: begin
                                    for (int i = 0; i < STATUS_WORDS; i++) begin
                                        if (wcnt == 4'(i)) begin
                                            shadow[i] <= io_din;
                                        end
                                    end
                                    // Last word goes straight into status alongside the buffered ones.
                                    if (wcnt == LAST_WORD) begin
                                        for (int i = 0; i < STATUS_WORDS - 1; i++) begin
                                            status[16*i +: 16] <= shadow[i];
                                        end
                                        status[16*(STATUS_WORDS-1) +: 16] <= io_din;
                                        status_pend <= 1'b1;
                                    end
                                end
                                CMD_JOY0: begin
                                    if (wcnt == 4'd0) begin
                                        joystick_0[15:0] <= io_din;
                                    end else if (wcnt == 4'd1) begin
                                        joystick_0[31:16] <= io_din;
                                    end
                                end
                                CMD_BUTTONS: begin
                                    if (wcnt == 4'd0) begin
                                        buttons <= io_din;
                                    end
                                end
`ifdef HPS_CMD_STATUS_GET_EN
                                CMD_STATUS_GET: begin
                                    io_dout <= status_word({1'b0, wcnt} + 5'd1);
                                end
`endif
                                default: begin
                                end
                            endcase
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Self-checking bench for hps_cmd_decoder (STATUS_WORDS=8): directed scenarios plus randomized
// transactions checked against a word-level behavioural model.
module tb_hps_cmd_decoder;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         io_enable;
    logic         io_strobe;
    logic [15:0]  io_din;
    logic [15:0]  io_dout;
    logic [15:0]  cmd;
    logic         cmd_active;
    logic [127:0] status;
    logic         status_set;
    logic [31:0]  joystick_0;
    logic [15:0]  buttons;

    hps_cmd_decoder #(.STATUS_WORDS(8)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io_enable  (io_enable),
        .io_strobe  (io_strobe),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .cmd        (cmd),
        .cmd_active (cmd_active),
        .status     (status),
        .status_set (status_set),
        .joystick_0 (joystick_0),
        .buttons    (buttons)
    );

    always #5 clk_sys = ~clk_sys;

`ifdef HPS_CMD_STATUS_GET_EN
    localparam bit GET_EN = 1'b1;
`else
    localparam bit GET_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Behavioural model state
    logic [15:0] m_status [8];
    logic [15:0] m_shadow [8];
    logic [31:0] m_joy;
    logic [15:0] m_buttons;
    int          m_pulses;

    always @(negedge clk_sys) begin
        if (status_set === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m_status_flat();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = m_status[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_status[i] = '0;
            m_shadow[i] = '0;
        end
        m_joy     = '0;
        m_buttons = '0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic enable_on();
        io_enable = 1'b1;
        tick();
    endtask

    task automatic enable_off();
        io_enable = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [15:0] w);
        io_din    = w;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".status"},   status,     m_status_flat());
        check({tag, ".joystick"}, joystick_0, m_joy);
        check({tag, ".buttons"},  buttons,    m_buttons);
    endtask

    // Word-level model of a payload word at index k for command c.
    task automatic model_word(input logic [15:0] c, input int k, input logic [15:0] w);
        if (c == 16'h001E && k < 8) begin
            m_shadow[k] = w;
            if (k == 7) begin
                for (int i = 0; i < 8; i++) m_status[i] = m_shadow[i];
                m_pulses++;
            end
        end else if (c == 16'h0002 && k == 0) begin
            m_joy[15:0] = w;
        end else if (c == 16'h0002 && k == 1) begin
            m_joy[31:16] = w;
        end else if (c == 16'h0004 && k == 0) begin
            m_buttons = w;
        end
    endtask

    function automatic logic [15:0] m_dout(input logic [15:0] c, input int next_idx);
        if (GET_EN && c == 16'h0029 && next_idx < 8) return m_status[next_idx];
        return 16'h0000;
    endfunction

    task automatic run_txn(input string tag, input logic [15:0] c, input int n);
        logic [15:0] w;
        enable_on();
        strobe(c);
        check({tag, ".cmd"}, cmd, c);
        check({tag, ".cmd_active"}, cmd_active, 1'b1);
        check({tag, ".dout_cmd"}, io_dout, m_dout(c, 0));
        for (int k = 0; k < n; k++) begin
            w = 16'($urandom);
            strobe(w);
            model_word(c, k, w);
            check({tag, ".dout"}, io_dout, m_dout(c, k + 1));
        end
        check_outputs(tag);
        enable_off();
        check({tag, ".idle_active"}, cmd_active, 1'b0);
        check({tag, ".idle_dout"}, io_dout, 16'h0000);
        check({tag, ".cmd_hold"}, cmd, c);
        tick();
        tick();
        check({tag, ".pulses"}, pulses, m_pulses);
    endtask

    initial begin
        logic [15:0] c;
        int          sel;
        int          n;

        reset     = 1'b1;
        io_enable = 1'b0;
        io_strobe = 1'b0;
        io_din    = '0;
        m_pulses  = 0;
        model_reset();
        #1;
        check("rst.dout", io_dout, 16'h0);
        check("rst.cmd", cmd, 16'h0);
        check("rst.active", cmd_active, 1'b0);
        check("rst.status_set", status_set, 1'b0);
        check_outputs("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Full STATUS_SET with 0x1111..0x8888
        enable_on();
        strobe(16'h001E);
        check("ss.active", cmd_active, 1'b1);
        for (int k = 0; k < 8; k++) begin
            strobe(16'(16'h1111 * (k + 1)));
            model_word(16'h001E, k, 16'(16'h1111 * (k + 1)));
            check("ss.status", status, m_status_flat());
            check("ss.set_low", status_set, 1'b0);
        end
        check("ss.value", status, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
        tick();
        check("ss.set_pulse", status_set, 1'b1);
        tick();
        check("ss.set_end", status_set, 1'b0);
        enable_off();
        tick();
        check("ss.pulses", pulses, 1);

        // STATUS_GET readback (unknown command when the macro is absent)
        run_txn("get", 16'h0029, 9);

        // Aborted STATUS_SET after 3 words
        run_txn("abort", 16'h001E, 3);
        check("abort.status", status, 128'h8888_7777_6666_5555_4444_3333_2222_1111);

        // JOY0 then BUTTONS with fixed words
        enable_on();
        strobe(16'h0002);
        strobe(16'hBEEF);
        check("joy.low", joystick_0, 32'h0000_BEEF);
        strobe(16'hDEAD);
        check("joy.full", joystick_0, 32'hDEAD_BEEF);
        enable_off();
        enable_on();
        strobe(16'h0004);
        strobe(16'h00A5);
        check("btn", buttons, 16'h00A5);
        enable_off();
        m_joy     = 32'hDEAD_BEEF;
        m_buttons = 16'h00A5;

        // Strobe coincident with io_enable falling is dropped
        enable_on();
        strobe(16'h0004);
        io_din    = 16'h1234;
        io_strobe = 1'b1;
        io_enable = 1'b0;
        tick();
        io_strobe = 1'b0;
        check("drop.buttons", buttons, 16'h00A5);
        check("drop.active", cmd_active, 1'b0);
        strobe(16'h5678);
        check("drop.idle_buttons", buttons, 16'h00A5);

        // Unknown command with 20 words
        run_txn("unk", 16'h00FF, 20);

        // Randomized transactions
        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin c = 16'h001E; n = int'($urandom_range(8, 11)); end
                1: begin c = 16'h001E; n = int'($urandom_range(1, 7)); end
                2: begin c = 16'h0002; n = int'($urandom_range(0, 3)); end
                3: begin c = 16'h0004; n = int'($urandom_range(0, 2)); end
                4: begin
                    c = 16'($urandom);
                    if (c == 16'h001E || c == 16'h0002 || c == 16'h0004 || c == 16'h0029) c = 16'h00FF;
                    n = int'($urandom_range(0, 20));
                end
                default: begin c = 16'h0029; n = int'($urandom_range(0, 10)); end
            endcase
            run_txn("rand", c, n);
        end

        // Reset between clock edges during JOY0
        enable_on();
        strobe(16'h0002);
        strobe(16'hABCD);
        m_joy[15:0] = 16'hABCD;
        check("rj.low", joystick_0, m_joy);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("rj.dout", io_dout, 16'h0);
        check("rj.cmd", cmd, 16'h0);
        check("rj.active", cmd_active, 1'b0);
        check("rj.status_set", status_set, 1'b0);
        check_outputs("rj");
        tick();
        reset = 1'b0;
        tick();
        strobe(16'h5A5A);
        strobe(16'h1357);
        check_outputs("rj.after");
        enable_off();
        check("rj.pulses", pulses, m_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
